// File: rtl/gshare_ckpt_predictor.sv
// -----------------------------------------------------------------------------
// gshare_ckpt_predictor
//
// Multi-slot gshare direction predictor for the fetch stage. Each lookup
// predicts FETCH_W sequential slots using the BTB hit mask. Speculative global
// history is checkpointed per one-hot branch tag so that a mispredict can
// restore it. The 2-bit pattern history table (PHT) is trained through a
// read-modify-write pipeline. Back-to-back updates to the same index forward
// the in-flight write. After reset the PHT initialises itself to weakly
// not-taken.
//
// Ports
//   i_clk, i_resetn      clock, asynchronous active-low reset
//   ready                PHT initialisation finished, requests/updates legal
//   req_valid/pc/hit     fetch lookup (slot s pc = req_pc + 4*s)
//   pred_valid/taken/bhr response one cycle after the request
//   ckpt_we/slot/tag     checkpoint one branch of the current response
//   res_*                branch resolution: training and history recovery
//   bhr_spec             current speculative history
//   ckpt_err             sticky: recovery referenced an invalid checkpoint
// -----------------------------------------------------------------------------
module gshare_ckpt_predictor #(
    parameter int BHR_W   = 10,
    parameter int FETCH_W = 2,
    parameter int NTAG    = 5,
    localparam int SLOT_W = (FETCH_W > 1) ? $clog2(FETCH_W) : 1
) (
    input  logic               i_clk,
    input  logic               i_resetn,
    output logic               ready,
    input  logic               req_valid,
    input  logic [31:0]        req_pc,
    input  logic [FETCH_W-1:0] req_hit,
    output logic               pred_valid,
    output logic [FETCH_W-1:0] pred_taken,
    output logic [BHR_W-1:0]   pred_bhr,
    input  logic               ckpt_we,
    input  logic [SLOT_W-1:0]  ckpt_slot,
    input  logic [NTAG-1:0]    ckpt_tag,
    input  logic               res_valid,
    input  logic [31:0]        res_pc,
    input  logic [BHR_W-1:0]   res_bhr,
    input  logic               res_taken,
    input  logic               res_mispredict,
    input  logic [NTAG-1:0]    res_tag,
    input  logic [NTAG-1:0]    res_kill_mask,
    output logic [BHR_W-1:0]   bhr_spec,
    output logic               ckpt_err
);

    localparam int PHT_N = 1 << BHR_W;

    typedef enum logic [0:0] {ST_INIT, ST_RUN} state_t;

    state_t             state_reg, state_next;
    logic [BHR_W-1:0]   init_cnt_reg, init_cnt_next;

    logic [1:0]         pht [PHT_N];

    // lookup pipeline
    logic [BHR_W-1:0]   look_idx [FETCH_W];
    logic [1:0]         rd_cnt_reg [FETCH_W];
    logic               lk_valid_reg;
    logic [FETCH_W-1:0] lk_hit_reg;
    logic [BHR_W-1:0]   lk_bhr_reg;

    // speculative history and checkpoints
    logic [BHR_W-1:0]   bhr_spec_reg;
    logic [BHR_W-1:0]   hist_stage [FETCH_W+1];
    logic [FETCH_W-1:0] taken_vec;
    logic               found_taken;
    logic [NTAG-1:0]    ckpt_valid_reg, ckpt_valid_next;
    logic [BHR_W-1:0]   ckpt_reg [NTAG];
    logic [BHR_W-1:0]   ckpt_sel;
    logic               ckpt_hit;
    logic               ckpt_err_reg;
    logic               mispredict;
    logic               alloc;

    // training pipeline (U1 = read stage, U2 = write stage)
    logic [BHR_W-1:0]   res_idx;
    logic               upd_valid_reg;
    logic [BHR_W-1:0]   upd_idx_reg;
    logic               upd_taken_reg;
    logic [1:0]         upd_cnt_reg;
    logic [1:0]         upd_wdata;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_reg    <= ST_INIT;
            init_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
        case (state_reg)
            ST_INIT: begin
                init_cnt_next = init_cnt_reg + 1'b1;
                if (init_cnt_reg == BHR_W'(PHT_N - 1)) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    assign ready = (state_reg == ST_RUN);

    // A mispredict only counts once the table is live.
    assign mispredict = ready & res_valid & res_mispredict;

    // ------------------------------------------------------------ indices
    // Adding 4*s never disturbs pc[1:0], so the slot index only needs the
    // word-address bits of req_pc.
    genvar gi;
    generate
        for (gi = 0; gi < FETCH_W; gi++) begin : g_slot_idx
            logic [BHR_W-1:0] slot_word;
            assign slot_word    = req_pc[2 +: BHR_W] + BHR_W'(gi);
            assign look_idx[gi] = slot_word ^ bhr_spec_reg;
        end
    endgenerate

    assign res_idx = res_pc[2 +: BHR_W] ^ res_bhr;

    // Saturating update of the counter held in the U2 stage.
    always_comb begin
        upd_wdata = upd_cnt_reg;
        if (upd_taken_reg) begin
            if (upd_cnt_reg != 2'b11) upd_wdata = upd_cnt_reg + 2'b01;
        end else begin
            if (upd_cnt_reg != 2'b00) upd_wdata = upd_cnt_reg - 2'b01;
        end
    end

    // ------------------------------------------------------------ PHT RAM
    // Reads are registered and see the pre-write contents, so a lookup of an
    // index written in the same cycle returns the old value. The U1 read is
    // the one exception: it takes the U2 write data when the indices match,
    // which keeps back-to-back updates to one entry from being lost.
    always_ff @(posedge i_clk) begin
        if (state_reg == ST_INIT) begin
            pht[init_cnt_reg] <= 2'b01;
        end else if (upd_valid_reg) begin
            pht[upd_idx_reg] <= upd_wdata;
        end
        for (int s = 0; s < FETCH_W; s++) begin
            rd_cnt_reg[s] <= pht[look_idx[s]];
        end
        if (upd_valid_reg && (upd_idx_reg == res_idx)) begin
            upd_cnt_reg <= upd_wdata;
        end else begin
            upd_cnt_reg <= pht[res_idx];
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            upd_valid_reg <= 1'b0;
            upd_idx_reg   <= '0;
            upd_taken_reg <= 1'b0;
        end else begin
            upd_valid_reg <= ready & res_valid;
            upd_idx_reg   <= res_idx;
            upd_taken_reg <= res_taken;
        end
    end

    // ------------------------------------------------------------- lookup
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            lk_valid_reg <= 1'b0;
            lk_hit_reg   <= '0;
            lk_bhr_reg   <= '0;
        end else begin
            lk_valid_reg <= ready & req_valid & ~mispredict;
            if (ready & req_valid & ~mispredict) begin
                lk_hit_reg <= req_hit;
                lk_bhr_reg <= bhr_spec_reg;
            end
        end
    end

    // Walk the slots in order: every hit slot up to and including the first
    // taken one shifts its direction in; hist_stage[s] is the history seen
    // just before slot s would shift.
    always_comb begin
        found_taken   = 1'b0;
        taken_vec     = '0;
        hist_stage[0] = bhr_spec_reg;
        for (int s = 0; s < FETCH_W; s++) begin
            if (lk_hit_reg[s] && !found_taken) begin
                taken_vec[s]    = rd_cnt_reg[s][1];
                hist_stage[s+1] = {hist_stage[s][BHR_W-2:0], rd_cnt_reg[s][1]};
                found_taken     = rd_cnt_reg[s][1];
            end else begin
                hist_stage[s+1] = hist_stage[s];
            end
        end
    end

    assign pred_valid = lk_valid_reg & ~mispredict;
    assign pred_taken = pred_valid ? taken_vec : '0;
    assign pred_bhr   = lk_bhr_reg;
    assign alloc      = pred_valid & ckpt_we;

    // -------------------------------------------------------- checkpoints
    always_comb begin
        ckpt_sel = '0;
        for (int t = 0; t < NTAG; t++) begin
            if (res_tag[t]) ckpt_sel = ckpt_sel | ckpt_reg[t];
        end
    end

    assign ckpt_hit = |(ckpt_valid_reg & res_tag);

    // Releases happen first so a same-cycle allocation of a tag wins.
    always_comb begin
        ckpt_valid_next = ckpt_valid_reg;
        if (mispredict) begin
            ckpt_valid_next = ckpt_valid_next & ~(res_kill_mask | res_tag);
        end else if (ready & res_valid) begin
            ckpt_valid_next = ckpt_valid_next & ~res_tag;
        end
        if (alloc) begin
            ckpt_valid_next = ckpt_valid_next | ckpt_tag;
        end
    end

    generate
        for (gi = 0; gi < NTAG; gi++) begin : g_ckpt
            always_ff @(posedge i_clk or negedge i_resetn) begin
                if (!i_resetn) begin
                    ckpt_reg[gi] <= '0;
                end else if (alloc && ckpt_tag[gi]) begin
                    ckpt_reg[gi] <= hist_stage[ckpt_slot];
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            bhr_spec_reg   <= '0;
            ckpt_valid_reg <= '0;
            ckpt_err_reg   <= 1'b0;
        end else begin
            ckpt_valid_reg <= ckpt_valid_next;
            if (mispredict) begin
                if (ckpt_hit) begin
                    bhr_spec_reg <= {ckpt_sel[BHR_W-2:0], res_taken};
                end else begin
                    ckpt_err_reg <= 1'b1;
                end
            end else if (pred_valid) begin
                bhr_spec_reg <= hist_stage[FETCH_W];
            end
        end
    end

    assign bhr_spec = bhr_spec_reg;
    assign ckpt_err = ckpt_err_reg;

    // Address bits that never reach an index, and the checkpoint MSB that
    // falls off during recovery.
    logic unused_bits;
    assign unused_bits = ^{req_pc[31:2+BHR_W], req_pc[1:0],
                           res_pc[31:2+BHR_W], res_pc[1:0], ckpt_sel[BHR_W-1]};

endmodule

// File: tb/tb_gshare_ckpt_predictor.sv
// -----------------------------------------------------------------------------
// tb_gshare_ckpt_predictor
//
// Directed bench for gshare_ckpt_predictor (BHR_W=10, FETCH_W=2, NTAG=5).
// Expected values are hand-computed; bhr_m holds the expected speculative
// history between transactions.
// -----------------------------------------------------------------------------
module tb_gshare_ckpt_predictor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ready;
    logic        req_valid = 1'b0;
    logic [31:0] req_pc = '0;
    logic [1:0]  req_hit = '0;
    logic        pred_valid;
    logic [1:0]  pred_taken;
    logic [9:0]  pred_bhr;
    logic        ckpt_we = 1'b0;
    logic [0:0]  ckpt_slot = '0;
    logic [4:0]  ckpt_tag = '0;
    logic        res_valid = 1'b0;
    logic [31:0] res_pc = '0;
    logic [9:0]  res_bhr = '0;
    logic        res_taken = 1'b0;
    logic        res_mispredict = 1'b0;
    logic [4:0]  res_tag = '0;
    logic [4:0]  res_kill_mask = '0;
    logic [9:0]  bhr_spec;
    logic        ckpt_err;

    int          checks = 0;
    int          errors = 0;
    logic [9:0]  bhr_m = '0;

    gshare_ckpt_predictor dut (
        .i_clk          (clk),
        .i_resetn       (rst_n),
        .ready          (ready),
        .req_valid      (req_valid),
        .req_pc         (req_pc),
        .req_hit        (req_hit),
        .pred_valid     (pred_valid),
        .pred_taken     (pred_taken),
        .pred_bhr       (pred_bhr),
        .ckpt_we        (ckpt_we),
        .ckpt_slot      (ckpt_slot),
        .ckpt_tag       (ckpt_tag),
        .res_valid      (res_valid),
        .res_pc         (res_pc),
        .res_bhr        (res_bhr),
        .res_taken      (res_taken),
        .res_mispredict (res_mispredict),
        .res_tag        (res_tag),
        .res_kill_mask  (res_kill_mask),
        .bhr_spec       (bhr_spec),
        .ckpt_err       (ckpt_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [4:0] tag, input logic taken, input logic mis,
                           input logic [4:0] kill, input logic [31:0] pc, input logic [9:0] bhr);
        res_valid      = 1'b1;
        res_pc         = pc;
        res_bhr        = bhr;
        res_taken      = taken;
        res_mispredict = mis;
        res_tag        = tag;
        res_kill_mask  = kill;
        tick();
        res_valid      = 1'b0;
        res_mispredict = 1'b0;
    endtask

    task automatic train(input logic [31:0] pc, input logic taken);
        resolve(5'b00000, taken, 1'b0, 5'b00000, pc, 10'h000);
        $display("train pc=%h taken=%b", pc, taken);
    endtask

    // Mispredict recovery; its training side lands on index 0x3FF, never looked up.
    task automatic recover(input string name, input logic [4:0] tag, input logic taken,
                           input logic [4:0] kill, input logic [9:0] exp_bhr, input logic exp_err);
        resolve(tag, taken, 1'b1, kill, 32'h0000_0FFC, 10'h000);
        check({name, ".bhr"}, bhr_spec, exp_bhr);
        check({name, ".err"}, ckpt_err, exp_err);
        $display("recover %s tag=%b taken=%b bhr=%h err=%b", name, tag, taken, bhr_spec, ckpt_err);
        bhr_m = exp_bhr;
    endtask

    task automatic fetch(input string name, input logic [31:0] pc, input logic [1:0] hit,
                         input logic [1:0] exp_taken, input logic [9:0] exp_after,
                         input logic we, input logic slot, input logic [4:0] tag);
        req_valid = 1'b1;
        req_pc    = pc;
        req_hit   = hit;
        tick();
        req_valid = 1'b0;
        check({name, ".valid"}, pred_valid, 1'b1);
        check({name, ".taken"}, pred_taken, exp_taken);
        check({name, ".pbhr"}, pred_bhr, bhr_m);
        ckpt_we   = we;
        ckpt_slot = slot;
        ckpt_tag  = tag;
        tick();
        ckpt_we   = 1'b0;
        check({name, ".bhr"}, bhr_spec, exp_after);
        $display("fetch %s pc=%h hit=%b taken=%b bhr=%h", name, pc, hit, exp_taken, bhr_spec);
        bhr_m = exp_after;
    endtask

    // Shift one direction into the history: index 0x040 holds a taken
    // counter, 0x200 an untouched weakly-not-taken one.
    task automatic shift_in(input logic b);
        logic [9:0]  base;
        logic [31:0] pc;
        base = b ? 10'h040 : 10'h200;
        pc   = {20'h0, base ^ bhr_m, 2'b00};
        fetch("shift", pc, 2'b01, {1'b0, b}, {bhr_m[8:0], b}, 1'b0, 1'b0, 5'b00000);
    endtask

    task automatic count_init(input string name);
        int n;
        n = 0;
        while (!ready && n < 1100) begin
            tick();
            n++;
        end
        check(name, n, 1024);
        $display("%s: ready after %0d cycles", name, n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc;

        // ---------------- reset values
        #12;
        check("rst.ready", ready, 1'b0);
        check("rst.pvalid", pred_valid, 1'b0);
        check("rst.ptaken", pred_taken, 2'b00);
        check("rst.pbhr", pred_bhr, 10'h000);
        check("rst.bhr", bhr_spec, 10'h000);
        check("rst.err", ckpt_err, 1'b0);
        #10 rst_n = 1'b1;
        count_init("init_len");

        // ---------------- every index reads weakly not-taken
        for (int i = 0; i < 512; i++) begin
            req_valid = 1'b1;
            req_pc    = 32'(i) << 3;
            req_hit   = 2'b11;
            tick();
            check("sweep.valid", pred_valid, 1'b1);
            check("sweep.taken", pred_taken, 2'b00);
        end
        req_valid = 1'b0;
        tick();
        check("sweep.bhr", bhr_spec, 10'h000);
        $display("sweep: 512 lookups over all 1024 indices");

        // ---------------- two taken updates on idx 0x040 -> counter 11
        train(32'h0000_0100, 1'b1);
        train(32'h0000_0100, 1'b1);
        tick();
        fetch("t2", 32'h0000_0100, 2'b11, 2'b01, 10'h001, 1'b0, 1'b0, 5'b00000);

        // ---------------- four back-to-back not-taken: 11->10->01->00->00
        train(32'h0000_0100, 1'b0);
        train(32'h0000_0100, 1'b0);
        train(32'h0000_0100, 1'b0);
        train(32'h0000_0100, 1'b0);
        tick();
        train(32'h0000_0100, 1'b1);   // 00 -> 01, still not taken
        tick();
        fetch("t3a", 32'h0000_0104, 2'b01, 2'b00, 10'h002, 1'b0, 1'b0, 5'b00000);
        train(32'h0000_0100, 1'b1);   // 01 -> 10, taken
        tick();
        fetch("t3b", 32'h0000_0108, 2'b01, 2'b01, 10'h005, 1'b0, 1'b0, 5'b00000);

        // ---------------- build history 0x0A5 (bits MSB first)
        shift_in(1'b0); shift_in(1'b0); shift_in(1'b1); shift_in(1'b0); shift_in(1'b1);
        shift_in(1'b0); shift_in(1'b0); shift_in(1'b1); shift_in(1'b0); shift_in(1'b1);
        check("t4.bhr0a5", bhr_spec, 10'h0A5);

        // checkpoint tag 00100 at 0x0A5, then tag 01000 on slot 1
        fetch("ck1", {20'h0, 10'h200 ^ 10'h0A5, 2'b00}, 2'b01, 2'b00, 10'h14A, 1'b1, 1'b0, 5'b00100);
        fetch("ck2", 32'h0000_0D28, 2'b11, 2'b00, 10'h128, 1'b1, 1'b1, 5'b01000);
        recover("rec1", 5'b00100, 1'b1, 5'b01000, 10'h14B, 1'b0);
        recover("killed", 5'b01000, 1'b0, 5'b00000, 10'h14B, 1'b1);

        // ---------------- slot-1 checkpoint value: 0x14B -> 0x296 -> 0x12C
        fetch("ck3", {20'h0, 10'h200 ^ 10'h14B, 2'b00}, 2'b11, 2'b00, 10'h12C, 1'b1, 1'b1, 5'b00001);
        recover("rec_s1", 5'b00001, 1'b1, 5'b00000, 10'h12D, 1'b1);

        // ---------------- correct resolve releases its tag
        fetch("ck4", {20'h0, 10'h200 ^ 10'h12D, 2'b00}, 2'b01, 2'b00, 10'h25A, 1'b1, 1'b0, 5'b00010);
        resolve(5'b00010, 1'b0, 1'b0, 5'b00000, 32'h0000_0FFC, 10'h000);
        check("release.bhr", bhr_spec, 10'h25A);
        recover("released", 5'b00010, 1'b1, 5'b00000, 10'h25A, 1'b1);

        // ---------------- mispredict in a response cycle wins
        fetch("ck5", {20'h0, 10'h200 ^ 10'h25A, 2'b00}, 2'b01, 2'b00, 10'h0B4, 1'b1, 1'b0, 5'b10000);
        pc        = {20'h0, 10'h040 ^ bhr_m, 2'b00};
        req_valid = 1'b1;
        req_pc    = pc;
        req_hit   = 2'b01;
        tick();
        check("race.pre_valid", pred_valid, 1'b1);
        res_valid      = 1'b1;
        res_mispredict = 1'b1;
        res_tag        = 5'b10000;
        res_taken      = 1'b1;
        res_kill_mask  = 5'b00000;
        res_pc         = 32'h0000_0FFC;
        res_bhr        = 10'h000;
        ckpt_we        = 1'b1;
        ckpt_slot      = 1'b0;
        ckpt_tag       = 5'b00001;
        #1;
        check("race.valid", pred_valid, 1'b0);
        check("race.taken", pred_taken, 2'b00);
        tick();
        res_valid      = 1'b0;
        res_mispredict = 1'b0;
        req_valid      = 1'b0;
        ckpt_we        = 1'b0;
        check("race.bhr", bhr_spec, 10'h0B5);
        check("race.squash", pred_valid, 1'b0);
        $display("race: mispredict over response, bhr=%h", bhr_spec);
        bhr_m = 10'h0B5;
        recover("dropped", 5'b00001, 1'b0, 5'b00000, 10'h0B5, 1'b1);

        // ---------------- asynchronous reset, then again mid-INIT
        #3 rst_n = 1'b0;
        #1;
        check("arst.ready", ready, 1'b0);
        check("arst.bhr", bhr_spec, 10'h000);
        check("arst.err", ckpt_err, 1'b0);
        check("arst.pvalid", pred_valid, 1'b0);
        #3 rst_n = 1'b1;
        req_valid = 1'b1;
        req_pc    = 32'h0000_0100;
        req_hit   = 2'b01;
        res_valid = 1'b1;
        res_pc    = 32'h0000_0100;
        res_bhr   = 10'h000;
        res_taken = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("init.ignored", pred_valid, 1'b0);
        end
        check("init.ready", ready, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("arst2.ready", ready, 1'b0);
        req_valid = 1'b0;
        res_valid = 1'b0;
        #2 rst_n = 1'b1;
        count_init("reinit_len");
        bhr_m = 10'h000;
        fetch("reinit", 32'h0000_0100, 2'b01, 2'b00, 10'h000, 1'b0, 1'b0, 5'b00000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
